bram11_rd_seq: RTL and testbench

// - Initiator for the 11-word byte-addressed BRAM port (EN, WE[3:0], Di, A, Do; Do valid the cycle after A).
// - Owns one tap BRAM (read-only) and one data BRAM (circular sample buffer).
// - Per accepted input sample: writes it to the data BRAM, then streams 11 (tap, data) pairs, newest sample with tap 0, to the FIR MAC.

---
 rtl/fir_bram_pkg.sv | 21 ++
 rtl/rd_skid_buf.sv | 66 ++++++
 rtl/bram11_rd_seq.sv | 131 +++++++++++++
 tb/tb_bram11_rd_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_bram_pkg.sv
// Shared constants, state encoding and address helper for the 11-word BRAM
// read sequencer.
package fir_bram_pkg;

   localparam int NTAPS  = 11;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 4;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_READ = 2'd2
   } state_t;

   // BRAM ports are byte addressed; words sit on 4-byte boundaries.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
      return ADDR_W'({idx, 2'b00});
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry valid/ready buffer for {tap, data, last} pairs captured from the
// BRAM read ports; count reports entries left after this cycle's pop.
module rd_skid_buf
   import fir_bram_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              push,
   input  logic [DATA_W-1:0] push_tap,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_tap,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [1:0]        count
);

   localparam int EW = 2 * DATA_W + 1;

   logic [EW-1:0] e0_q;
   logic [EW-1:0] e1_q;
   logic [EW-1:0] push_e;
   logic [1:0]    occ_q;
   logic          pop;

   assign push_e    = {push_tap, push_data, push_last};
   assign out_valid = (occ_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign out_tap   = e0_q[EW-1 -: DATA_W];
   assign out_data  = e0_q[DATA_W:1];
   assign out_last  = out_valid && e0_q[0];
   // Net of the pop lets the issue gate sustain one pair per cycle.
   assign count     = occ_q - {1'b0, pop};

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         occ_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (occ_q == 2'd2) begin
                  e0_q <= e1_q;
                  e1_q <= push_e;
               end else begin
                  e0_q <= push_e;
               end
            end
            2'b10: begin
               if (occ_q == 2'd0) e0_q <= push_e;
               else               e1_q <= push_e;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               e0_q  <= e1_q;
               occ_q <= occ_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bram11_rd_seq.sv
// Sequencer: zeroes the sample BRAM, writes each accepted sample into the
// circular buffer, then streams 11 (tap, sample) pairs newest-first.
module bram11_rd_seq
   import fir_bram_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_tap,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              tap_EN,
   output logic [3:0]        tap_WE,
   output logic [DATA_W-1:0] tap_Di,
   output logic [ADDR_W-1:0] tap_A,
   input  logic [DATA_W-1:0] tap_Do,
   output logic              data_EN,
   output logic [3:0]        data_WE,
   output logic [DATA_W-1:0] data_Di,
   output logic [ADDR_W-1:0] data_A,
   input  logic [DATA_W-1:0] data_Do,
   output logic [1:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are
   // both high; a raised valid and its payload hold until that transfer.

   state_t           state_q, state_n;
   logic [IDX_W-1:0] init_idx_q;
   logic [IDX_W-1:0] wptr_q;
   logic [IDX_W-1:0] k_q;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_vld_q;
   logic             rd_last_q;
   logic             accept;
   logic             issue;
   logic             frame_done;
   logic [1:0]       buf_count;
   logic [2:0]       pending;

   assign rd_idx     = (wptr_q >= k_q) ? (wptr_q - k_q) : (wptr_q + IDX_W'(NTAPS) - k_q);
   assign pending    = {1'b0, buf_count} + {2'b00, rd_vld_q};
   assign accept     = (state_q == ST_IDLE) && in_valid;
   assign frame_done = (state_q == ST_READ) && out_valid && out_ready && out_last;
   assign tap_WE     = 4'h0;
   assign tap_Di     = '0;
   assign dbg_state  = state_q;

   always_comb begin
      state_n  = state_q;
      in_ready = 1'b0;
      issue    = 1'b0;
      tap_EN   = 1'b0;
      tap_A    = '0;
      data_EN  = 1'b0;
      data_WE  = 4'h0;
      data_Di  = '0;
      data_A   = '0;
      case (state_q)
         ST_INIT: begin
            data_EN = 1'b1;
            data_WE = 4'hF;
            data_A  = word_addr(init_idx_q);
            if (init_idx_q == IDX_W'(NTAPS - 1)) state_n = ST_IDLE;
         end
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_EN = 1'b1;
               data_WE = 4'hF;
               data_A  = word_addr(wptr_q);
               data_Di = in_data;
               state_n = ST_READ;
            end
         end
         ST_READ: begin
            // Never let buffered plus in-flight pairs exceed the two skid slots.
            if ((k_q < IDX_W'(NTAPS)) && (pending < 3'd2)) begin
               issue   = 1'b1;
               tap_EN  = 1'b1;
               tap_A   = word_addr(k_q);
               data_EN = 1'b1;
               data_A  = word_addr(rd_idx);
            end
            if (frame_done) state_n = ST_IDLE;
         end
         default: state_n = ST_INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
         wptr_q     <= '0;
         k_q        <= '0;
         rd_vld_q   <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q   <= state_n;
         rd_vld_q  <= issue;
         rd_last_q <= issue && (k_q == IDX_W'(NTAPS - 1));
         if (state_q == ST_INIT)
            init_idx_q <= (init_idx_q == IDX_W'(NTAPS - 1)) ? '0 : init_idx_q + IDX_W'(1);
         if (accept)     k_q <= '0;
         else if (issue) k_q <= k_q + IDX_W'(1);
         if (frame_done)
            wptr_q <= (wptr_q == IDX_W'(NTAPS - 1)) ? '0 : wptr_q + IDX_W'(1);
      end
   end

   rd_skid_buf u_skid (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (rd_vld_q),
      .push_tap  (tap_Do),
      .push_data (data_Do),
      .push_last (rd_last_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tap   (out_tap),
      .out_data  (out_data),
      .out_last  (out_last),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_bram11_rd_seq.sv
// Bench for bram11_rd_seq: BRAM models, randomized samples and backpressure,
// a sample-history reference model feeding an expected-pair queue.
module tb_bram11_rd_seq;

   localparam int NT = 11;
   localparam int DW = 32;
   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_tap;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          tap_EN;
   logic [3:0]    tap_WE;
   logic [DW-1:0] tap_Di;
   logic [AW-1:0] tap_A;
   logic [DW-1:0] tap_Do;
   logic          data_EN;
   logic [3:0]    data_WE;
   logic [DW-1:0] data_Di;
   logic [AW-1:0] data_A;
   logic [DW-1:0] data_Do;
   logic [1:0]    dbg_state;

   // clock / reset
   always #5 CLK = ~CLK;

   bram11_rd_seq dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tap   (out_tap),
      .out_data  (out_data),
      .out_last  (out_last),
      .tap_EN    (tap_EN),
      .tap_WE    (tap_WE),
      .tap_Di    (tap_Di),
      .tap_A     (tap_A),
      .tap_Do    (tap_Do),
      .data_EN   (data_EN),
      .data_WE   (data_WE),
      .data_Di   (data_Di),
      .data_A    (data_A),
      .data_Do   (data_Do),
      .dbg_state (dbg_state)
   );

   // BRAM models: one-cycle read latency, byte addresses
   logic [DW-1:0] tap_mem  [NT];
   logic [DW-1:0] data_mem [NT];
   logic [DW-1:0] ref_tap  [NT];
   logic          tap_load = 1'b0;
   logic [9:0]    ta_w;
   logic [9:0]    da_w;

   assign ta_w = tap_A[AW-1:2];
   assign da_w = data_A[AW-1:2];

   always @(posedge CLK) begin
      if (tap_load) begin
         for (int i = 0; i < NT; i++) begin
            tap_mem[i]  <= ref_tap[i];
            data_mem[i] <= 32'hBAD0_0000 | 32'(i);
         end
      end else begin
         if (tap_EN) begin
            if (ta_w < 10'(NT)) begin
               if (tap_WE != 4'h0) tap_mem[ta_w[3:0]] <= tap_Di;
               tap_Do <= tap_mem[ta_w[3:0]];
            end else begin
               tap_Do <= 'x;
            end
         end
         if (data_EN) begin
            if (da_w < 10'(NT)) begin
               if (data_WE != 4'h0) data_mem[da_w[3:0]] <= data_Di;
               data_Do <= data_mem[da_w[3:0]];
            end else begin
               data_Do <= 'x;
            end
         end
      end
   end

   // counters and check helpers
   int n_vec  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail_note(input string nm);
      n_vec++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", nm, $time);
   endtask

   // out_ready driver: 0 always, 1 alternate, 2 random, 3 five-cycle stall at k=4
   int rdy_mode       = 0;
   int stall_left     = 5;
   int pairs_in_frame = 0;

   always @(posedge CLK) begin
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: out_ready = ~out_ready;
         2: out_ready = ($urandom_range(0, 3) != 0);
         default: begin
            if (pairs_in_frame == 4 && stall_left > 0) begin
               out_ready  = 1'b0;
               stall_left = stall_left - 1;
            end else begin
               out_ready = 1'b1;
            end
         end
      endcase
      if (rdy_mode != 3) stall_left = 5;
   end

   // scoreboard: reference model pushes on accept, monitor pops on consume
   logic [64:0]   exp_q[$];
   logic [DW-1:0] hist[$];
   int            n_acc = 0;
   logic          hold_v = 1'b0;
   logic [64:0]   hold_e;
   logic [DW-1:0] mon_dk;

   always @(negedge CLK) begin
      if (!RST_N) begin
         exp_q.delete();
         hist.delete();
         n_acc          = 0;
         pairs_in_frame = 0;
         hold_v         = 1'b0;
      end else begin
         if (hold_v) begin
            chk("stall_valid_held", 65'(out_valid), 65'(1));
            chk("stall_pair_held", {out_tap, out_data, out_last}, hold_e);
         end
         hold_v = out_valid && !out_ready;
         hold_e = {out_tap, out_data, out_last};

         if (tap_EN) chk("tap_port_readonly", 65'({tap_WE, tap_Di}), 65'(0));

         if (in_valid && in_ready) begin
            chk("wr_en", 65'(data_EN), 65'(1));
            chk("wr_we", 65'(data_WE), 65'(4'hF));
            chk("wr_di", 65'(data_Di), 65'(in_data));
            chk("wr_addr", 65'(data_A), 65'((n_acc % NT) * 4));
            hist.push_front(in_data);
            if (hist.size() > NT) void'(hist.pop_back());
            // pair k: tap k with the k-th most recent sample since reset (0 if none)
            for (int k = 0; k < NT; k++) begin
               mon_dk = (k < hist.size()) ? hist[k] : 32'd0;
               exp_q.push_back({ref_tap[k], mon_dk, (k == NT - 1)});
            end
            n_acc++;
         end

         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_pair: actual %0h required none", {out_tap, out_data, out_last});
            end else begin
               chk("pair", {out_tap, out_data, out_last}, exp_q.pop_front());
            end
            pairs_in_frame = out_last ? 0 : pairs_in_frame + 1;
         end
      end
   end

   // driver tasks
   task automatic check_init();
      for (int i = 0; i < NT; i++) begin
         @(negedge CLK);
         chk("init_en", 65'(data_EN), 65'(1));
         chk("init_we", 65'(data_WE), 65'(4'hF));
         chk("init_di", 65'(data_Di), 65'(0));
         chk("init_addr", 65'(data_A), 65'(i * 4));
         chk("init_in_ready", 65'(in_ready), 65'(0));
         chk("init_out_valid", 65'(out_valid), 65'(0));
      end
      @(negedge CLK);
      chk("idle_in_ready", 65'(in_ready), 65'(1));
      chk("idle_state", 65'(dbg_state), 65'(2'd1));
   endtask

   task automatic do_reset(input int n, input logic load);
      @(posedge CLK); #1;
      RST_N    = 1'b0;
      tap_load = load;
      @(posedge CLK); #1;
      tap_load = 1'b0;
      @(negedge CLK);
      chk("rst_out_valid", 65'(out_valid), 65'(0));
      chk("rst_out_last", 65'(out_last), 65'(0));
      chk("rst_out_tap", 65'(out_tap), 65'(0));
      chk("rst_out_data", 65'(out_data), 65'(0));
      chk("rst_in_ready", 65'(in_ready), 65'(0));
      chk("rst_state", 65'(dbg_state), 65'(2'd0));
      repeat (n) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      check_init();
   endtask

   task automatic send_sample(input logic [DW-1:0] x);
      int w = 0;
      @(posedge CLK); #1;
      in_valid = 1'b1;
      in_data  = x;
      @(negedge CLK);
      while (!in_ready && w < 300) begin
         @(negedge CLK);
         w++;
      end
      if (!in_ready) fail_note("in_ready_wait");
      @(posedge CLK); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   task automatic drain();
      int w = 0;
      while ((exp_q.size() != 0 || out_valid) && w < 3000) begin
         @(negedge CLK);
         w++;
      end
      chk("drain_queue_empty", 65'(exp_q.size()), 65'(0));
      chk("drain_out_idle", 65'(out_valid), 65'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      RST_N    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      for (int i = 0; i < NT; i++) ref_tap[i] = 32'(i + 1);
      do_reset(2, 1'b1);

      // single sample: latency and burst shape
      send_sample(32'd5);
      @(negedge CLK); chk("lat_cycle1", 65'(out_valid), 65'(0));
      @(negedge CLK); chk("lat_cycle2", 65'(out_valid), 65'(0));
      for (int i = 0; i < NT; i++) begin
         @(negedge CLK);
         chk("burst_valid", 65'(out_valid), 65'(1));
      end
      @(negedge CLK); chk("burst_end", 65'(out_valid), 65'(0));
      drain();

      // 13 samples from clean buffer: history and pointer wrap
      do_reset(1, 1'b0);
      for (int s = 1; s <= 13; s++) send_sample(32'(s));
      drain();

      // backpressure patterns
      rdy_mode = 1;
      send_sample($urandom);
      send_sample($urandom);
      drain();
      rdy_mode = 3;
      send_sample(32'h0000_00AB);
      drain();

      // random taps, random samples, random gaps and readiness
      rdy_mode = 0;
      for (int i = 0; i < NT; i++) ref_tap[i] = $urandom;
      do_reset(1, 1'b1);
      rdy_mode = 2;
      for (int s = 0; s < 20; s++) begin
         repeat ($urandom_range(0, 4)) @(posedge CLK);
         send_sample($urandom);
      end
      drain();

      // reset mid-frame
      rdy_mode = 0;
      for (int i = 0; i < NT; i++) ref_tap[i] = 32'(i + 1);
      do_reset(1, 1'b1);
      send_sample(32'd9);
      w = 0;
      @(negedge CLK); #1;
      while (pairs_in_frame != 5 && w < 500) begin
         @(negedge CLK); #1;
         w++;
      end
      if (pairs_in_frame != 5) fail_note("wait_pair5");
      @(posedge CLK); #1;
      RST_N = 1'b0;
      @(posedge CLK); #1;
      RST_N = 1'b1;
      check_init();
      send_sample(32'd7);
      drain();

      chk("final_queue_empty", 65'(exp_q.size()), 65'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
